// File: rtl/pipe_hazard_unit_if.sv
// Hazard-unit bundle: ID/EX hazard inputs from the pipeline and the stall/flush enables plus status returned to it.
// Combinational controls, no backpressure; the master is the pipeline and the slave is the hazard unit.
interface pipe_hazard_unit_if #(
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int STALL_CNT_WIDTH    = 32
);
  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rs1_addr;
  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rs2_addr;
  logic                          ID_Rs1_used;
  logic                          ID_Rs2_used;
  logic                          ID_Mem_wr_en;
  logic [REGFILE_ADDR_WIDTH-1:0] EX_Rd_addr;
  logic                          EX_Mem_rd_en;
  logic                          EX_Branch_taken;
  logic                          EX_Div_valid;
  logic                          PC_stall;
  logic                          IF_ID_stall;
  logic                          IF_ID_flush;
  logic                          ID_EX_stall;
  logic                          ID_EX_flush;
  logic                          Div_busy;
  logic                          Div_done;
  logic [STALL_CNT_WIDTH-1:0]    Stall_cycles;

  modport master (
    output ID_Rs1_addr, ID_Rs2_addr, ID_Rs1_used, ID_Rs2_used, ID_Mem_wr_en,
    output EX_Rd_addr, EX_Mem_rd_en, EX_Branch_taken, EX_Div_valid,
    input  PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
    input  Div_busy, Div_done, Stall_cycles
  );

  modport slave (
    input  ID_Rs1_addr, ID_Rs2_addr, ID_Rs1_used, ID_Rs2_used, ID_Mem_wr_en,
    input  EX_Rd_addr, EX_Mem_rd_en, EX_Branch_taken, EX_Div_valid,
    output PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
    output Div_busy, Div_done, Stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Stall/flush controller for load-use, taken branches and the multi-cycle divider, with a saturating stall counter.
// Controls are combinational from the inputs and the registered state; the block never waits on anyone else.
module pipe_hazard_unit #(
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int DIV_CYCLES         = 8,
  parameter int STALL_CNT_WIDTH    = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  pipe_hazard_unit_if.slave hz
);

  typedef enum logic {
    RUN      = 1'b0,
    DIV_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 2);

  state_t                     r_state;
  logic [7:0]                 r_div_cnt;
  logic [STALL_CNT_WIDTH-1:0] r_stall_cycles;

  logic [REGFILE_ADDR_WIDTH-1:0] w_rs1;
  logic [REGFILE_ADDR_WIDTH-1:0] w_rs2;
  logic [REGFILE_ADDR_WIDTH-1:0] w_rd;
  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_load_use;
  logic w_div_start;
  logic w_div_stall;
  logic w_div_done;
  logic w_pc_stall;
  logic w_if_id_stall;
  logic w_if_id_flush;
  logic w_id_ex_stall;
  logic w_id_ex_flush;

  assign w_rs1 = hz.ID_Rs1_addr;
  assign w_rs2 = hz.ID_Rs2_addr;
  assign w_rd  = hz.EX_Rd_addr;

  // A store that depends on the load only through its data operand is covered by MEM store-data forwarding.
  assign w_rs1_hit  = hz.ID_Rs1_used && (w_rs1 == w_rd);
  assign w_rs2_hit  = hz.ID_Rs2_used && (w_rs2 == w_rd) && !(hz.ID_Mem_wr_en && (w_rs1 != w_rd));
  assign w_load_use = hz.EX_Mem_rd_en && (w_rd != '0) && (w_rs1_hit || w_rs2_hit);

  assign w_div_start = (r_state == RUN) && hz.EX_Div_valid && !hz.EX_Branch_taken;
  assign w_div_stall = w_div_start || ((r_state == DIV_WAIT) && (r_div_cnt != 8'd0));
  assign w_div_done  = (r_state == DIV_WAIT) && (r_div_cnt == 8'd0);

  always_comb begin
    w_pc_stall    = 1'b0;
    w_if_id_stall = 1'b0;
    w_if_id_flush = 1'b0;
    w_id_ex_stall = 1'b0;
    w_id_ex_flush = 1'b0;
    if (Reset) begin
      w_pc_stall = 1'b0;
    end else if (hz.EX_Branch_taken) begin
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
    end else if (w_div_stall) begin
      w_pc_stall    = 1'b1;
      w_if_id_stall = 1'b1;
      w_id_ex_stall = 1'b1;
    end else if (w_load_use) begin
      w_pc_stall    = 1'b1;
      w_if_id_stall = 1'b1;
      w_id_ex_flush = 1'b1;
    end
  end

  assign hz.PC_stall     = w_pc_stall;
  assign hz.IF_ID_stall  = w_if_id_stall;
  assign hz.IF_ID_flush  = w_if_id_flush;
  assign hz.ID_EX_stall  = w_id_ex_stall;
  assign hz.ID_EX_flush  = w_id_ex_flush;
  assign hz.Div_busy     = !Reset && (r_state == DIV_WAIT);
  assign hz.Div_done     = !Reset && w_div_done;
  assign hz.Stall_cycles = r_stall_cycles;

  // The divide sequence keeps counting through a branch flush; only reset aborts it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state        <= RUN;
      r_div_cnt      <= 8'd0;
      r_stall_cycles <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_div_start) begin
            r_state   <= DIV_WAIT;
            r_div_cnt <= DIV_LOAD;
          end
        end
        DIV_WAIT: begin
          if (r_div_cnt != 8'd0) begin
            r_div_cnt <= r_div_cnt - 8'd1;
          end else begin
            r_state <= RUN;
          end
        end
        default: begin
          r_state   <= RUN;
          r_div_cnt <= 8'd0;
        end
      endcase
      if (w_pc_stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + STALL_CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed vectors for pipe_hazard_unit with a queue scoreboard; a 4-bit-counter instance shares the stimulus.
module tb_pipe_hazard_unit;

  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] LU   = 7'b1100100;
  localparam logic [6:0] BR   = 7'b0010100;
  localparam logic [6:0] DIV  = 7'b1101000;
  localparam logic [6:0] DIVW = 7'b1101010;
  localparam logic [6:0] DONE = 7'b0000011;

  typedef struct {
    logic [6:0]  ctl;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, st, ld, br, dv;

  exp_t        q[$];
  exp_t        e;
  logic [6:0]  got32, got4;
  logic [31:0] m_cnt;
  logic [3:0]  m_cnt4;
  int          checks = 0;
  int          errors = 0;

  always #5 Clk = ~Clk;

  pipe_hazard_unit_if #(.REGFILE_ADDR_WIDTH(5), .STALL_CNT_WIDTH(32)) hz32 ();
  pipe_hazard_unit_if #(.REGFILE_ADDR_WIDTH(5), .STALL_CNT_WIDTH(4))  hz4 ();

  assign hz32.ID_Rs1_addr = rs1;  assign hz4.ID_Rs1_addr = rs1;
  assign hz32.ID_Rs2_addr = rs2;  assign hz4.ID_Rs2_addr = rs2;
  assign hz32.ID_Rs1_used = u1;   assign hz4.ID_Rs1_used = u1;
  assign hz32.ID_Rs2_used = u2;   assign hz4.ID_Rs2_used = u2;
  assign hz32.ID_Mem_wr_en = st;  assign hz4.ID_Mem_wr_en = st;
  assign hz32.EX_Rd_addr = rd;    assign hz4.EX_Rd_addr = rd;
  assign hz32.EX_Mem_rd_en = ld;  assign hz4.EX_Mem_rd_en = ld;
  assign hz32.EX_Branch_taken = br; assign hz4.EX_Branch_taken = br;
  assign hz32.EX_Div_valid = dv;  assign hz4.EX_Div_valid = dv;

  pipe_hazard_unit #(.REGFILE_ADDR_WIDTH(5), .DIV_CYCLES(8), .STALL_CNT_WIDTH(32)) u_dut32 (
    .Clk   (Clk),
    .Reset (Reset),
    .hz    (hz32.slave)
  );

  pipe_hazard_unit #(.REGFILE_ADDR_WIDTH(5), .DIV_CYCLES(8), .STALL_CNT_WIDTH(4)) u_dut4 (
    .Clk   (Clk),
    .Reset (Reset),
    .hz    (hz4.slave)
  );

  // Monitor: every cycle the DUT presents a full set of controls; compare at the falling edge.
  always @(negedge Clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      got32 = {hz32.PC_stall, hz32.IF_ID_stall, hz32.IF_ID_flush, hz32.ID_EX_stall,
               hz32.ID_EX_flush, hz32.Div_busy, hz32.Div_done};
      got4  = {hz4.PC_stall, hz4.IF_ID_stall, hz4.IF_ID_flush, hz4.ID_EX_stall,
               hz4.ID_EX_flush, hz4.Div_busy, hz4.Div_done};
      checks = checks + 1;
      if (got32 !== e.ctl) begin
        errors = errors + 1;
        $display("FAIL ctl32 t=%0t got=%b exp=%b", $time, got32, e.ctl);
      end
      checks = checks + 1;
      if (got4 !== e.ctl) begin
        errors = errors + 1;
        $display("FAIL ctl4 t=%0t got=%b exp=%b", $time, got4, e.ctl);
      end
      checks = checks + 1;
      if (hz32.Stall_cycles !== e.cnt) begin
        errors = errors + 1;
        $display("FAIL stall_cnt32 t=%0t got=%0d exp=%0d", $time, hz32.Stall_cycles, e.cnt);
      end
      checks = checks + 1;
      if (hz4.Stall_cycles !== e.cnt4) begin
        errors = errors + 1;
        $display("FAIL stall_cnt4 t=%0t got=%0d exp=%0d", $time, hz4.Stall_cycles, e.cnt4);
      end
    end
  end

  // One cycle of stimulus: use_v = {rs1_used, rs2_used, store}, ex_v = {load, branch, div}.
  task automatic cyc(input logic rst, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [2:0] use_v, input logic [4:0] d,
                     input logic [2:0] ex_v, input logic [6:0] ectl);
    exp_t x;
    Reset = rst;
    rs1 = r1;
    rs2 = r2;
    {u1, u2, st} = use_v;
    rd = d;
    {ld, br, dv} = ex_v;
    x.ctl  = ectl;
    x.cnt  = m_cnt;
    x.cnt4 = m_cnt4;
    q.push_back(x);
    if (rst) begin
      m_cnt  = 32'd0;
      m_cnt4 = 4'd0;
    end else if (ectl[6]) begin
      m_cnt = m_cnt + 32'd1;
      if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 4'd1;
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    Reset = 1'b1;
    rs1 = '0; rs2 = '0; rd = '0;
    u1 = 1'b0; u2 = 1'b0; st = 1'b0; ld = 1'b0; br = 1'b0; dv = 1'b0;
    m_cnt = 32'd0;
    m_cnt4 = 4'd0;
    @(posedge Clk);
    #1;

    cyc(1, 0, 0, 3'b000, 0, 3'b000, NONE);
    cyc(1, 5, 0, 3'b100, 5, 3'b101, NONE);
    cyc(0, 0, 0, 3'b000, 0, 3'b000, NONE);
    // Load-use on rs1, then the load has moved on
    cyc(0, 5, 0, 3'b100, 5, 3'b100, LU);
    cyc(0, 5, 0, 3'b100, 0, 3'b000, NONE);
    // Store-data exemption, then rs1 also depends
    cyc(0, 2, 7, 3'b111, 7, 3'b100, NONE);
    cyc(0, 7, 7, 3'b111, 7, 3'b100, LU);
    cyc(0, 0, 0, 3'b110, 0, 3'b100, NONE);
    cyc(0, 1, 3, 3'b110, 3, 3'b100, LU);
    // Full divide; EX_Div_valid held high in DIV_WAIT must be ignored
    cyc(0, 0, 0, 3'b000, 0, 3'b001, DIV);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 4, 0, 3'b100, 4, (i < 2) ? 3'b101 : 3'b000, DIVW);
    end
    cyc(0, 0, 0, 3'b000, 0, 3'b001, DONE);
    // Back-to-back divide aborted by reset in the third DIV_WAIT cycle
    cyc(0, 0, 0, 3'b000, 0, 3'b001, DIV);
    cyc(0, 0, 0, 3'b000, 0, 3'b000, DIVW);
    cyc(0, 0, 0, 3'b000, 0, 3'b000, DIVW);
    cyc(1, 0, 0, 3'b000, 0, 3'b000, NONE);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 3'b000, 0, 3'b000, NONE);
    end
    // Branch beats load-use and divide; divide with branch leaves FSM in RUN
    cyc(0, 5, 0, 3'b100, 5, 3'b110, BR);
    cyc(0, 0, 0, 3'b000, 0, 3'b011, BR);
    cyc(0, 0, 0, 3'b000, 0, 3'b000, NONE);
    // Saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      cyc(0, 6, 0, 3'b100, 6, 3'b100, LU);
    end
    cyc(0, 0, 0, 3'b000, 0, 3'b000, NONE);
    cyc(0, 0, 0, 3'b000, 0, 3'b000, NONE);

    @(negedge Clk);
    #1;
    checks = checks + 1;
    if (q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain left=%0d exp=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
